// File: rtl/ro_puf_sequencer_pkg.sv
// Shared types and constants for the ring-oscillator PUF sequencer.
package ro_puf_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMeasure,
        StSample,
        StDone
    } state_e;

    localparam int unsigned ChallengeWidth = 8;
    localparam int unsigned VoteRepeats    = 3;
    localparam int unsigned TimerWidth     = 16;

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module puf_window_timer
    import ro_puf_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [TimerWidth-1:0] load_value,
    output logic                  done
);

    logic [TimerWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/ro_puf_sequencer.sv
// Sequences a one-bit RO PUF cell to build a multi-bit response word.
// Optional PUF_MAJORITY_VOTE_EN: three measurements per bit, majority-voted.
module ro_puf_sequencer
    import ro_puf_sequencer_pkg::*;
#(
    parameter int unsigned RESP_BITS  = 16,
    parameter int unsigned WINDOW     = 1024,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ChallengeWidth-1:0] base_challenge,
    output logic                      busy,
    output logic [ChallengeWidth-1:0] challenge,
    output logic                      puf_reset,
    input  logic                      puf_out,
    output logic [RESP_BITS-1:0]      response,
    output logic                      resp_valid,
    input  logic                      resp_ready
);

    localparam int unsigned KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [KW-1:0] LastK = KW'(RESP_BITS - 1);
    // Timer counts load_value..0, so an interval of N cycles loads N-1.
    localparam logic [TimerWidth-1:0] RstLoad = TimerWidth'(RST_CYCLES - 1);
    localparam logic [TimerWidth-1:0] WinLoad = TimerWidth'(WINDOW - 1);

    state_e                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [ChallengeWidth-1:0] base_q, base_d;
    logic [ChallengeWidth-1:0] challenge_q, challenge_d;
    logic [RESP_BITS-1:0]      response_q, response_d;
    logic                      timer_load;
    logic [TimerWidth-1:0]     timer_value;
    logic                      timer_done;
    logic                      last_rep;
    logic                      sample_bit;

    puf_window_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] rep_q, rep_d;
    logic [1:0] ones_q, ones_d;

    assign last_rep   = (rep_q == 2'(VoteRepeats - 1));
    assign sample_bit = ((ones_q + {1'b0, puf_out}) >= 2'd2);

    always_comb begin
        rep_d  = rep_q;
        ones_d = ones_q;
        if (state_q == StIdle && start) begin
            rep_d  = '0;
            ones_d = '0;
        end else if (state_q == StSample) begin
            if (last_rep) begin
                rep_d  = '0;
                ones_d = '0;
            end else begin
                rep_d  = rep_q + 1'b1;
                ones_d = ones_q + {1'b0, puf_out};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_q  <= '0;
            ones_q <= '0;
        end else begin
            rep_q  <= rep_d;
            ones_q <= ones_d;
        end
    end
`else
    assign last_rep   = 1'b1;
    assign sample_bit = puf_out;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        challenge_d = challenge_q;
        response_d  = response_q;
        timer_load  = 1'b0;
        timer_value = RstLoad;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d      = base_challenge;
                    challenge_d = base_challenge;
                    k_d         = '0;
                    response_d  = '0;
                    timer_load  = 1'b1;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                if (timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = WinLoad;
                    state_d     = StMeasure;
                end
            end
            StMeasure: begin
                if (timer_done) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                // Default: re-measure (vote repeat) or move to the next bit.
                timer_load = 1'b1;
                state_d    = StLoad;
                if (last_rep) begin
                    response_d[k_q] = sample_bit;
                    if (k_q == LastK) begin
                        timer_load = 1'b0;
                        state_d    = StDone;
                    end else begin
                        k_d         = k_q + 1'b1;
                        challenge_d = base_q + 8'(k_q) + 8'd1;
                    end
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            base_q      <= '0;
            challenge_q <= '0;
            response_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            challenge_q <= challenge_d;
            response_q  <= response_d;
        end
    end

    always_comb begin
        busy       = (state_q != StIdle);
        resp_valid = (state_q == StDone);
        puf_reset  = (state_q == StIdle) || (state_q == StLoad) || (state_q == StDone);
        challenge  = challenge_q;
        response   = response_q;
    end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Randomized self-checking bench for ro_puf_sequencer against a cycle-position model.
module tb_ro_puf_sequencer;

    localparam int RESP_BITS  = 4;
    localparam int WINDOW     = 8;
    localparam int RST_CYCLES = 2;
    localparam int P          = RST_CYCLES + WINDOW + 1;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int REPS = 3;
`else
    localparam int REPS = 1;
`endif
    localparam int N = RESP_BITS * P * REPS;
    localparam int OW = 11 + RESP_BITS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [7:0]           base_challenge;
    logic                 busy;
    logic [7:0]           challenge;
    logic                 puf_reset;
    logic                 puf_out;
    logic [RESP_BITS-1:0] response;
    logic                 resp_valid;
    logic                 resp_ready;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ro_puf_sequencer #(
        .RESP_BITS  (RESP_BITS),
        .WINDOW     (WINDOW),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_challenge (base_challenge),
        .busy           (busy),
        .challenge      (challenge),
        .puf_reset      (puf_reset),
        .puf_out        (puf_out),
        .response       (response),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready)
    );

    // Runs one request from an idle negedge. mode: 0 random, 1 ones, 2 mask at samples,
    // 3 two-of-three ones per bit. abort_at >= 0 asserts reset at that cycle.
    task automatic request(input logic [7:0] base, input int mode,
                           input logic [RESP_BITS-1:0] mask, input int hold,
                           input int abort_at);
        logic [RESP_BITS-1:0] exp_resp;
        logic [OW-1:0]        obs;
        logic [OW-1:0]        expv;
        logic [7:0]           exp_ch;
        logic                 exp_prst;
        logic                 smp;
        int                   bit_i;
        int                   rep;
        int                   ones;
        int                   skip;
        exp_resp = '0;
        ones     = 0;
        skip     = 0;
        start          = 1'b1;
        base_challenge = base;
        resp_ready     = 1'b0;
        @(negedge clk);
        start          = 1'b0;
        base_challenge = 8'($urandom);
        for (int c = 0; c < N; c++) begin
            bit_i = c / (P * REPS);
            rep   = (c / P) % REPS;
            smp   = ((c % P) == P - 1);
            if (c == abort_at) begin
                reset = 1'b1;
                #1;
                obs  = {busy, resp_valid, puf_reset, challenge, response};
                expv = {3'b001, 8'h00, {RESP_BITS{1'b0}}};
                checks++;
                if (obs !== expv) $display("FAIL async_reset: got %h want %h", obs, expv);
                else passed++;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            exp_ch   = base + 8'(bit_i);
            exp_prst = ((c % P) < RST_CYCLES);
            obs      = {busy, resp_valid, puf_reset, challenge, response};
            expv     = {1'b1, 1'b0, exp_prst, exp_ch, exp_resp};
            checks++;
            if (obs !== expv) $display("FAIL cycle %0d: got %h want %h", c, obs, expv);
            else passed++;
            if ((c % P) == 0 && rep == 0) skip = $urandom_range(0, 2);
            case (mode)
                1:       puf_out = 1'b1;
                2:       puf_out = smp ? mask[bit_i] : 1'($urandom);
                3:       puf_out = smp ? (rep != skip) : 1'($urandom);
                default: puf_out = 1'($urandom);
            endcase
            if (smp) begin
                ones += int'(puf_out);
                if (rep == REPS - 1) begin
                    exp_resp[bit_i] = (2 * ones > REPS);
                    ones = 0;
                end
            end
            @(negedge clk);
        end
        exp_ch = base + 8'(RESP_BITS - 1);
        for (int h = 0; h <= hold; h++) begin
            obs  = {busy, resp_valid, puf_reset, challenge, response};
            expv = {3'b111, exp_ch, exp_resp};
            checks++;
            if (obs !== expv) $display("FAIL done_hold %0d: got %h want %h", h, obs, expv);
            else passed++;
            puf_out = 1'($urandom);
            start   = (hold > 0) && (h == hold / 2);
            if (h == hold) begin
                resp_ready = 1'b1;
                start      = 1'b1;
            end
            @(negedge clk);
        end
        resp_ready = 1'b0;
        start      = 1'b0;
        obs  = {busy, resp_valid, puf_reset, challenge, {RESP_BITS{1'b0}}};
        expv = {3'b001, exp_ch, {RESP_BITS{1'b0}}};
        checks++;
        if (obs !== expv) $display("FAIL idle_after_handshake: got %h want %h", obs, expv);
        else passed++;
    endtask

    task automatic test_reset();
        logic [OW-1:0] obs;
        reset          = 1'b1;
        start          = 1'b0;
        resp_ready     = 1'b0;
        puf_out        = 1'b0;
        base_challenge = 8'h00;
        @(negedge clk);
        obs = {busy, resp_valid, puf_reset, challenge, response};
        checks++;
        if (obs !== {3'b001, 8'h00, {RESP_BITS{1'b0}}})
            $display("FAIL reset_values: got %h", obs);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        obs = {busy, resp_valid, puf_reset, challenge, response};
        checks++;
        if (obs !== {3'b001, 8'h00, {RESP_BITS{1'b0}}})
            $display("FAIL idle_after_reset: got %h", obs);
        else passed++;
    endtask

    task automatic test_all_ones();
        request(8'h3A, 1, '0, 0, -1);
    endtask

    task automatic test_sample_only();
        request(8'h3A, 2, 4'b0101, 0, -1);
    endtask

    task automatic test_wrap();
        request(8'hFE, 0, '0, 0, -1);
    endtask

    task automatic test_hold();
        request(8'($urandom), 0, '0, 10, -1);
    endtask

    task automatic test_mid_reset();
        request(8'h55, 1, '0, 0, 2 * P * REPS + RST_CYCLES + 3);
        request(8'h90, 0, '0, 1, -1);
    endtask

    task automatic test_vote();
        request(8'hC3, 3, '0, 0, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            request(8'($urandom), 0, '0, $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_sample_only();
        test_wrap();
        test_hold();
        test_mid_reset();
        test_vote();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
